// File: rtl/sliding_window_adder_if.sv
// Sample/result bus for sliding_window_adder: the producer drives samples and
// flush, the adder drives the pipelined windowed sum and its sample count.
interface sliding_window_adder_if #(
  parameter int data_width = 10,
  parameter int N          = 4
);
  localparam int SW = data_width + $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic                  inp_valid;
  logic [data_width-1:0] inp;
  logic                  flush;
  logic                  outp_valid;
  logic [SW-1:0]         outp;
  logic [CW-1:0]         outp_count;
  logic                  outp_full;

  modport master (
    output inp_valid, inp, flush,
    input  outp_valid, outp, outp_count, outp_full
  );

  modport slave (
    input  inp_valid, inp, flush,
    output outp_valid, outp, outp_count, outp_full
  );
endinterface

// File: rtl/sliding_window_adder.sv
// Running sum over the last N accepted samples, followed by adder_regs output
// register stages that hold their last valid result through idle cycles.
module sliding_window_adder #(
  parameter int data_width  = 10,
  parameter int N           = 4,
  parameter int adder_regs  = 2,
  parameter int signed_mode = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  sliding_window_adder_if.slave bus
);
  localparam int SW = data_width + $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] count;
    logic [SW-1:0] sum;
  } stage_t;

  logic [data_width-1:0] r_win [N];
  logic [SW-1:0]         r_sum;
  logic [CW-1:0]         r_count;
  logic                  r_acc;

  stage_t w_head;
  stage_t w_tail;

  // SW is wide enough for N extreme samples, so modular add/subtract is exact.
  function automatic logic [SW-1:0] ext(input logic [data_width-1:0] x);
    if (signed_mode != 0) return SW'($signed(x));
    return SW'(x);
  endfunction

  // A stage only captures new data when its upstream slot is valid, so the
  // outputs keep the last result while bubbles pass through.
  function automatic stage_t advance(input stage_t prev, input stage_t cur);
    stage_t nxt;
    nxt       = prev.valid ? prev : cur;
    nxt.valid = prev.valid;
    return nxt;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the shift chain samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the window is a small register file, not a RAM, so it can and
      // must be cleared by reset to keep the sum consistent with its contents.
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_acc   <= 1'b0;
    end else begin
      r_acc <= bus.inp_valid;
      if (bus.flush) begin
        for (int i = 0; i < N; i++) r_win[i] <= '0;
        r_sum   <= '0;
        r_count <= '0;
        if (bus.inp_valid) begin
          r_win[0] <= bus.inp;
          r_sum    <= ext(bus.inp);
          r_count  <= CW'(1);
        end
      end else if (bus.inp_valid) begin
        r_win[0] <= bus.inp;
        for (int i = 1; i < N; i++) r_win[i] <= r_win[i-1];
        r_sum <= r_sum + ext(bus.inp) - ext(r_win[N-1]);
        if (r_count != CW'(N)) r_count <= r_count + CW'(1);
      end
    end
  end

  assign w_head = '{valid: r_acc, count: r_count, sum: r_sum};

  generate
    if (adder_regs == 0) begin : g_direct
      assign w_tail = w_head;
    end else begin : g_pipe
      stage_t r_pipe [adder_regs];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < adder_regs; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= advance(w_head, r_pipe[0]);
          for (int i = 1; i < adder_regs; i++) r_pipe[i] <= advance(r_pipe[i-1], r_pipe[i]);
        end
      end

      assign w_tail = r_pipe[adder_regs-1];
    end
  endgenerate

  assign bus.outp_valid = w_tail.valid;
  assign bus.outp       = w_tail.sum;
  assign bus.outp_count = w_tail.count;
  assign bus.outp_full  = (w_tail.count == CW'(N));
endmodule
